// File: rtl/inst_mem_responder_pkg.sv
// Shared FSM encoding and constants for the instruction-memory responder
// and its optional cache array.
package inst_mem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int unsigned INST_BYTES      = 4;
   localparam int unsigned RAM_LAT_DEFAULT = 1;

endpackage

// File: rtl/inst_mem_responder_cache.sv
// Direct-mapped instruction cache storage: one word per line, one
// combinational read port for lookup and one synchronous write port for fill.
module inst_cache_array
   import inst_mem_responder_pkg::*;
#(
   parameter int unsigned LINES = 64
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic [29:0]             rd_addr,
   output logic                    hit,
   output logic [INST_BYTES*8-1:0] rd_data,
   input  logic                    wr_en,
   input  logic [29:0]             wr_addr,
   input  logic [INST_BYTES*8-1:0] wr_data
);

   localparam int unsigned IW = $clog2(LINES);

   logic [LINES-1:0]        valid;
   logic [29-IW:0]          tags  [LINES];
   logic [INST_BYTES*8-1:0] words [LINES];
   logic [IW-1:0]           rd_idx;
   logic [IW-1:0]           wr_idx;

   assign rd_idx  = rd_addr[IW-1:0];
   assign wr_idx  = wr_addr[IW-1:0];
   assign hit     = valid[rd_idx] && (tags[rd_idx] == rd_addr[29:IW]);
   assign rd_data = words[rd_idx];

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (wr_en) begin
         tags[wr_idx]  <= wr_addr[29:IW];
         words[wr_idx] <= wr_data;
      end
   end

endmodule

// File: rtl/inst_mem_responder.sv
// Fetch-side memory responder: reads four bytes over the shared 8-bit RAM port
// and returns one little-endian word. Optional cache enabled by INST_CACHE_EN.
module inst_mem_responder
   import inst_mem_responder_pkg::*;
#(
   parameter int unsigned ICACHE_LINES = 64,
   parameter int unsigned RAM_LAT      = RAM_LAT_DEFAULT
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        _clear,
   input  logic        _need_inst,
   input  logic [31:0] _fetch_pc,
   output logic        _mem_busy,
   output logic        _inst_ready,
   output logic [31:0] _inst_out,
   input  logic        _bus_grant,
   output logic        _ram_req,
   output logic [31:0] _ram_a,
   input  logic [7:0]  _ram_din
);

   localparam int unsigned KW = $clog2(RAM_LAT + 1);

   if ((ICACHE_LINES < 2) || ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0) || (RAM_LAT < 1))
   begin : g_param_check
      $error("inst_mem_responder: ICACHE_LINES must be a power of two and RAM_LAT >= 1");
   end

   state_t             state;
   logic [31:0]        pc;
   logic [31:0]        word;
   logic [31:0]        word_next;
   logic [2:0]         issue_cnt;
   logic [2:0]         recv_cnt;
   logic [RAM_LAT-1:0] pipe;
   logic [RAM_LAT:0]   pipe_next;
   logic [KW-1:0]      kill_cnt;
   logic               req_q;
   logic               fire;
   logic               capture;
   logic               accept;
   logic               hit;
   logic [31:0]        hit_word;
   logic               hit_pend;
   logic [31:0]        hit_data;

   assign _ram_req  = req_q & rdy_in;
   assign _ram_a    = pc + 32'(issue_cnt);
   assign _mem_busy = (state != IDLE);
   assign fire      = _ram_req & _bus_grant;
   assign pipe_next = {pipe, fire};
   // Bytes still in flight after an abort arrive while kill_cnt is non-zero.
   assign capture   = pipe[RAM_LAT-1] && (kill_cnt == '0);
   assign accept    = _need_inst && !_clear && (kill_cnt == '0);

   always_comb begin
      word_next = word;
      word_next[{recv_cnt[1:0], 3'b000} +: 8] = _ram_din;
   end

`ifdef INST_CACHE_EN
   logic fill;

   assign fill = rdy_in && (state != IDLE) && !_clear && capture
                 && (recv_cnt == 3'(INST_BYTES - 1));

   inst_cache_array #(
      .LINES (ICACHE_LINES)
   ) u_cache (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .rd_addr (_fetch_pc[31:2]),
      .hit     (hit),
      .rd_data (hit_word),
      .wr_en   (fill),
      .wr_addr (pc[31:2]),
      .wr_data (word_next)
   );
`else
   assign hit      = 1'b0;
   assign hit_word = '0;
`endif

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state       <= IDLE;
         pc          <= '0;
         word        <= '0;
         issue_cnt   <= '0;
         recv_cnt    <= '0;
         pipe        <= '0;
         kill_cnt    <= '0;
         req_q       <= 1'b0;
         hit_pend    <= 1'b0;
         hit_data    <= '0;
         _inst_ready <= 1'b0;
         _inst_out   <= '0;
      end else if (rdy_in) begin
         _inst_ready <= 1'b0;
         pipe        <= pipe_next[RAM_LAT-1:0];
         if (kill_cnt != '0) kill_cnt <= kill_cnt - KW'(1);
         case (state)
            IDLE: begin
               // A hit is answered one cycle after accept; a flush drops it.
               if (hit_pend) begin
                  hit_pend <= 1'b0;
                  if (!_clear) begin
                     _inst_ready <= 1'b1;
                     _inst_out   <= hit_data;
                  end
               end else if (accept) begin
                  if (hit) begin
                     hit_pend <= 1'b1;
                     hit_data <= hit_word;
                  end else begin
                     pc        <= _fetch_pc;
                     req_q     <= 1'b1;
                     issue_cnt <= '0;
                     recv_cnt  <= '0;
                     state     <= ISSUE;
                  end
               end
            end
            ISSUE, DRAIN: begin
               if (_clear) begin
                  state     <= IDLE;
                  req_q     <= 1'b0;
                  issue_cnt <= '0;
                  recv_cnt  <= '0;
                  kill_cnt  <= KW'(RAM_LAT);
               end else begin
                  if (fire) begin
                     issue_cnt <= issue_cnt + 3'd1;
                     if (issue_cnt == 3'(INST_BYTES - 1)) begin
                        req_q <= 1'b0;
                        state <= DRAIN;
                     end
                  end
                  if (capture) begin
                     word     <= word_next;
                     recv_cnt <= recv_cnt + 3'd1;
                     if (recv_cnt == 3'(INST_BYTES - 1)) begin
                        state       <= IDLE;
                        issue_cnt   <= '0;
                        recv_cnt    <= '0;
                        _inst_ready <= 1'b1;
                        _inst_out   <= word_next;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Self-checking bench for inst_mem_responder: byte-RAM model with latency 1,
// per-fetch expectations derived from the grant sequence and a word-level cache model.
module tb_inst_mem_responder;

   localparam int unsigned LINES = 64;
   localparam int unsigned IW    = $clog2(LINES);
`ifdef INST_CACHE_EN
   localparam bit CACHE_EN = 1'b1;
`else
   localparam bit CACHE_EN = 1'b0;
`endif

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        _clear;
   logic        _need_inst;
   logic [31:0] _fetch_pc;
   logic        _mem_busy;
   logic        _inst_ready;
   logic [31:0] _inst_out;
   logic        _bus_grant;
   logic        _ram_req;
   logic [31:0] _ram_a;
   logic [7:0]  _ram_din = 8'h00;

   int checks   = 0;
   int failures = 0;

   logic [31:0]   addr_log[$];
   bit            cv    [LINES];
   logic [29-IW:0] ctag [LINES];
   logic [31:0]   cdata [LINES];
   logic [31:0]   ra;

   inst_mem_responder #(
      .ICACHE_LINES (LINES),
      .RAM_LAT      (1)
   ) dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .rdy_in      (rdy_in),
      ._clear      (_clear),
      ._need_inst  (_need_inst),
      ._fetch_pc   (_fetch_pc),
      ._mem_busy   (_mem_busy),
      ._inst_ready (_inst_ready),
      ._inst_out   (_inst_out),
      ._bus_grant  (_bus_grant),
      ._ram_req    (_ram_req),
      ._ram_a      (_ram_a),
      ._ram_din    (_ram_din)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [7:0] mem(input logic [31:0] a);
      case (a)
         32'h100: mem = 8'h13;
         32'h101: mem = 8'h05;
         32'h102: mem = 8'h50;
         32'h103: mem = 8'h00;
         default: mem = ({a[4:0], a[7:5]} + a[15:8]) ^ a[23:16] ^ a[31:24] ^ 8'h5A;
      endcase
   endfunction

   // RAM answers one cycle after a granted request; otherwise the bus carries junk.
   always @(posedge clk_in) begin
      if (_ram_req && _bus_grant) begin
         addr_log.push_back(_ram_a);
         _ram_din <= mem(_ram_a);
      end else begin
         _ram_din <= 8'($urandom);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst_in     = 1'b0;
      rdy_in     = 1'b1;
      _clear     = 1'b0;
      _need_inst = 1'b0;
      _bus_grant = 1'b1;
      _fetch_pc  = '0;
      for (int i = 0; i < LINES; i++) cv[i] = 1'b0;
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      chk("rst_ready", _inst_ready, 0);
      chk("rst_out",   _inst_out,   0);
      chk("rst_busy",  _mem_busy,   0);
      chk("rst_req",   _ram_req,    0);
      chk("rst_ram_a", _ram_a,      0);
      @(posedge clk_in); #1;
      rst_in = 1'b1;
   endtask

   // gmask bit j is the grant offered in the (j+1)-th cycle after accept.
   task automatic do_fetch(input logic [31:0] a, input logic [31:0] gmask, input bit rnd);
      bit          g [48];
      int          grants, lat, m, exp_lat, idx;
      bit          exp_hit, busy_prev, busy_rdy;
      logic [31:0] exp_w, out_at;
      for (int j = 0; j < 48; j++)
         g[j] = (j >= 20) ? 1'b1 : (rnd ? ($urandom_range(0, 2) != 0) : gmask[j]);
      idx     = int'((a >> 2) % LINES);
      exp_hit = CACHE_EN && cv[idx] && (ctag[idx] == a[31:2+IW]);
      if (exp_hit) begin
         exp_lat = 1;
         exp_w   = cdata[idx];
      end else begin
         grants = 0;
         m      = 0;
         for (int j = 0; j < 48 && grants < 4; j++) begin
            if (g[j]) grants++;
            m = j + 1;
         end
         exp_lat = m + 1;
         exp_w   = {mem(a + 3), mem(a + 2), mem(a + 1), mem(a)};
      end
      addr_log.delete();
      _fetch_pc  = a;
      _need_inst = 1'b1;
      @(posedge clk_in); #1;
      _need_inst = 1'b0;
      grants    = 0;
      lat       = -1;
      busy_prev = 1'b0;
      busy_rdy  = 1'b1;
      out_at    = 'x;
      for (int k = 1; k <= 48 && lat < 0; k++) begin
         _bus_grant = g[k-1];
         @(negedge clk_in);
         if (_inst_ready) begin
            lat      = k - 1;
            out_at   = _inst_out;
            busy_rdy = _mem_busy;
         end else begin
            busy_prev = _mem_busy;
            chk("ram_req", _ram_req, (!exp_hit && grants < 4));
            if (_ram_req) chk("ram_a", _ram_a, a + grants);
            if (_ram_req && _bus_grant) grants++;
         end
         @(posedge clk_in); #1;
      end
      chk("latency",       lat,       exp_lat);
      chk("inst_out",      out_at,    exp_w);
      chk("busy_at_ready", busy_rdy,  0);
      chk("busy_before",   busy_prev, !exp_hit);
      chk("ram_reads",     addr_log.size(), exp_hit ? 0 : 4);
      for (int i = 0; i < addr_log.size() && i < 4; i++)
         chk("ram_addr_log", addr_log[i], a + i);
      _bus_grant = 1'b1;
      @(negedge clk_in);
      chk("ready_pulse", _inst_ready, 0);
      chk("out_hold",    _inst_out,   exp_w);
      if (CACHE_EN && !exp_hit) begin
         cv[idx]    = 1'b1;
         ctag[idx]  = a[31:2+IW];
         cdata[idx] = exp_w;
      end
      @(posedge clk_in); #1;
   endtask

   task automatic do_abort(input logic [31:0] a);
      int pulses = 0;
      _fetch_pc  = a;
      _need_inst = 1'b1;
      @(posedge clk_in); #1;
      _need_inst = 1'b0;
      _bus_grant = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         _clear = (k == 2);
         @(negedge clk_in);
         if (_inst_ready) pulses++;
         if (k == 3) begin
            chk("clr_busy", _mem_busy, 0);
            chk("clr_req",  _ram_req,  0);
         end
         @(posedge clk_in); #1;
      end
      _clear = 1'b0;
      chk("clr_no_ready", pulses, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      do_reset();
      do_fetch(32'h0000_0100, '1, 1'b0);
      do_reset();
      do_fetch(32'h0000_0100, 32'hFFFF_FFF9, 1'b0);

      do_abort(32'h0000_0300);
      do_fetch(32'h0000_0200, '1, 1'b0);
      do_fetch(32'h0000_0300, '1, 1'b0);

      _fetch_pc  = 32'h0000_0400;
      _need_inst = 1'b1;
      _clear     = 1'b1;
      @(posedge clk_in); #1;
      _need_inst = 1'b0;
      _clear     = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_in);
         chk("same_cycle_req",   _ram_req,     0);
         chk("same_cycle_busy",  _mem_busy,    0);
         chk("same_cycle_ready", _inst_ready,  0);
         @(posedge clk_in); #1;
      end

      do_fetch(32'hFFFF_FFFE, '1, 1'b1);
      for (int i = 0; i < 12; i++) begin
         ra = ($urandom_range(0, 1) == 1) ? 32'($urandom)
                                          : 32'h400 + 32'(4 * $urandom_range(0, 7));
         do_fetch(ra, '1, 1'b1);
      end

      do_reset();
      do_fetch(32'h0000_0100, '1, 1'b0);
      do_fetch(32'h0000_0100, '1, 1'b0);
      do_fetch(32'h0000_0100 + 4 * LINES, '1, 1'b0);
      do_fetch(32'h0000_0100, '1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
